// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO.
// Accepts words on a valid/ready stream, queues them, and serialises each as
// start + DATA_BITS (LSB first) + optional parity + STOP_BITS on an idle-high line.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9_600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  // Parity cell value: even parity is the XOR of the data bits, odd is its inverse.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    parity_of = (^d) ^ (PARITY == 2);
  endfunction

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       count;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;

  logic [2:0]           state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 baud_wrap;
  logic                 last_stop;

  assign full      = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign push      = in_valid && !full;
  assign baud_wrap = (baud_cnt == CNT_W'(BAUD_DIV - 1));
  assign last_stop = (bit_idx == 3'(STOP_BITS - 1));
  // A word leaves the FIFO when idle, or at the end of the last stop cell so
  // the next start cell follows with no idle gap.
  assign pop       = !empty && ((state == S_IDLE) ||
                                (state == S_STOP && baud_wrap && last_stop));
  assign busy      = (state != S_IDLE) || !empty;

  // FIFO storage: data only, discarded logically by the pointer reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Shift register and latched parity for the frame being sent.
  always_ff @(posedge clk) begin
    if (pop) begin
      shift   <= mem[rd_ptr];
      par_bit <= parity_of(mem[rd_ptr]);
    end else if (state == S_DATA && baud_wrap) begin
      shift   <= shift >> 1;
    end
  end

  // Frame sequencer; tx is registered so the line never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            state    <= S_START;
            tx       <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
          end
        end
        S_START: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            state    <= S_DATA;
            tx       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                state <= S_PAR;
                tx    <= par_bit;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        S_PAR: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            state    <= S_STOP;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (last_stop) begin
              bit_idx <= '0;
              if (!empty) begin
                state <= S_START;
                tx    <= 1'b0;
              end else begin
                state <= S_IDLE;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances (8N1, even parity, odd parity with two
// stop bits, default 9600 baud). Frame cells checked cycle by cycle from a vector
// table; a receive model on the 8N1 instance checks byte order via a queue.
module tb_uart_tx_fifo;

  logic clk;
  logic rst;

  logic [7:0] a_data, b_data, c_data, d_data;
  logic       a_valid, b_valid, c_valid, d_valid;
  logic       a_ready, b_ready, c_ready, d_ready;
  logic       a_tx, b_tx, c_tx, d_tx;
  logic       a_busy, b_busy, c_busy, d_busy;

  int n_cmp;
  int n_fail;
  logic [7:0] exp_q[$];
  logic       mon_en;
  int         stall [6];

  typedef struct {
    logic [7:0] data;
    logic [9:0] cells;  // bit i = line level during cell i (cell 0 = start)
  } vec_t;
  vec_t vecs [5];

  uart_tx_fifo #(.CLK_FREQ(100), .BAUD_RATE(10)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_ready), .tx(a_tx), .busy(a_busy));

  uart_tx_fifo #(.CLK_FREQ(100), .BAUD_RATE(10), .PARITY(1)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .tx(b_tx), .busy(b_busy));

  uart_tx_fifo #(.CLK_FREQ(100), .BAUD_RATE(10), .PARITY(2), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid),
    .in_ready(c_ready), .tx(c_tx), .busy(c_busy));

  uart_tx_fifo dut_d (
    .clk(clk), .rst(rst), .in_data(d_data), .in_valid(d_valid),
    .in_ready(d_ready), .tx(d_tx), .busy(d_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic cur_tx(input int sel);
    case (sel)
      0: cur_tx = a_tx;
      1: cur_tx = b_tx;
      2: cur_tx = c_tx;
      default: cur_tx = d_tx;
    endcase
  endfunction

  function automatic logic cur_busy(input int sel);
    case (sel)
      0: cur_busy = a_busy;
      1: cur_busy = b_busy;
      2: cur_busy = c_busy;
      default: cur_busy = d_busy;
    endcase
  endfunction

  function automatic logic cur_ready(input int sel);
    case (sel)
      0: cur_ready = a_ready;
      1: cur_ready = b_ready;
      2: cur_ready = c_ready;
      default: cur_ready = d_ready;
    endcase
  endfunction

  task automatic set_in(input int sel, input logic [7:0] d, input logic v);
    case (sel)
      0: begin a_data = d; a_valid = v; end
      1: begin b_data = d; b_valid = v; end
      2: begin c_data = d; c_valid = v; end
      default: begin d_data = d; d_valid = v; end
    endcase
  endtask

  // Push one word into an idle instance; returns 1 ns after the accepting edge.
  task automatic push_one(input int sel, input logic [7:0] d);
    set_in(sel, d, 1'b1);
    chk("ready_before_push", 32'(cur_ready(sel)), 32'd1);
    @(posedge clk); #1;
    set_in(sel, d, 1'b0);
    if (sel == 0) exp_q.push_back(d);
    chk("tx_high_at_accept", 32'(cur_tx(sel)), 32'd1);
    chk("busy_at_accept", 32'(cur_busy(sel)), 32'd1);
  endtask

  // Called 1 ns after the accepting edge; follows ncells cells of 10 cycles each.
  task automatic check_cells(input int sel, input logic [31:0] cells, input int ncells,
                             input string name);
    logic [31:0] got;
    logic        uniform;
    logic        busy_ok;
    got = '0;
    uniform = 1'b1;
    busy_ok = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < ncells * 10; i++) begin
      if (i % 10 == 0) got[i / 10] = cur_tx(sel);
      else if (cur_tx(sel) !== got[i / 10]) uniform = 1'b0;
      if (cur_busy(sel) !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
    end
    chk({name, "_cells"}, got, cells);
    chk({name, "_cell_timing"}, 32'(uniform), 32'd1);
    chk({name, "_busy_during"}, 32'(busy_ok), 32'd1);
    chk({name, "_busy_after"}, 32'(cur_busy(sel)), 32'd0);
    chk({name, "_tx_after"}, 32'(cur_tx(sel)), 32'd1);
  endtask

  // Reference 8N1 receiver on instance A, sampling mid-cell on the falling clock.
  initial begin
    logic [7:0] rx_byte;
    logic       frame_ok;
    forever begin
      @(negedge clk);
      if (mon_en && a_tx === 1'b0) begin
        repeat (4) @(negedge clk);
        frame_ok = (a_tx === 1'b0);
        for (int b = 0; b < 8; b++) begin
          repeat (10) @(negedge clk);
          rx_byte[b] = a_tx;
        end
        repeat (10) @(negedge clk);
        if (a_tx !== 1'b1) frame_ok = 1'b0;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rx_unexpected_frame: got %0h, expected none", rx_byte);
        end else begin
          chk("rx_byte", {23'd0, frame_ok, rx_byte}, {23'd0, 1'b1, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_cmp  = 0;
    n_fail = 0;
    mon_en = 1'b1;
    vecs[0] = '{data: 8'hA5, cells: 10'b1101001010};
    vecs[1] = '{data: 8'h00, cells: 10'b1000000000};
    vecs[2] = '{data: 8'hFF, cells: 10'b1111111110};
    vecs[3] = '{data: 8'h3C, cells: 10'b1001111000};
    vecs[4] = '{data: 8'h01, cells: 10'b1000000010};
    set_in(0, 8'h00, 1'b0);
    set_in(1, 8'h00, 1'b0);
    set_in(2, 8'h00, 1'b0);
    set_in(3, 8'h00, 1'b0);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", 32'(a_tx), 32'd1);
    chk("reset_busy", 32'(a_busy), 32'd0);
    chk("reset_ready", 32'(a_ready), 32'd1);
    chk("reset_tx_default", 32'(d_tx), 32'd1);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single frames from the vector table.
    for (int v = 0; v < 5; v++) begin
      push_one(0, vecs[v].data);
      check_cells(0, 32'(vecs[v].cells), 10, "vec");
      repeat (3) @(posedge clk);
      #1;
    end

    // Back-to-back: three words on consecutive cycles, no gap between frames.
    a_data = 8'h00; a_valid = 1'b1;
    exp_q.push_back(8'h00);
    @(posedge clk); #1;
    fork
      begin
        a_data = 8'hFF;
        chk("b2b_ready_1", 32'(a_ready), 32'd1);
        exp_q.push_back(8'hFF);
        @(posedge clk); #1;
        a_data = 8'h3C;
        chk("b2b_ready_2", 32'(a_ready), 32'd1);
        exp_q.push_back(8'h3C);
        @(posedge clk); #1;
        a_valid = 1'b0;
      end
      check_cells(0, 32'({10'b1001111000, 10'b1111111110, 10'b1000000000}), 30, "b2b");
    join
    repeat (3) @(posedge clk);
    #1;

    // FIFO full: six words held continuously; the sixth waits for the next pop.
    a_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_data = 8'(8'h11 * (i + 1));
      stall[i] = 0;
      while (!a_ready && stall[i] < 300) begin
        @(posedge clk); #1;
        stall[i]++;
      end
      exp_q.push_back(a_data);
      @(posedge clk); #1;
      if (i == 4) chk("full_ready_low", 32'(a_ready), 32'd0);
    end
    a_valid = 1'b0;
    chk("full_no_early_stall", stall[0] + stall[1] + stall[2] + stall[3] + stall[4], 0);
    chk("full_stall_cycles", stall[5], 97);
    n = 0;
    while (a_busy && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("full_drained", 32'(a_busy), 32'd0);
    chk("full_all_received", exp_q.size(), 0);

    // Even parity, then odd parity with two stop bits.
    push_one(1, 8'h07);
    check_cells(1, 32'({2'b11, 8'h07, 1'b0}), 11, "even_par");
    push_one(2, 8'h07);
    check_cells(2, 32'({3'b110, 8'h07, 1'b0}), 12, "odd_par_2stop");

    // Reset during the 4th data cell of 0x55 with two words queued.
    mon_en = 1'b0;
    a_data = 8'h55; a_valid = 1'b1;
    @(posedge clk); #1;
    a_data = 8'h01;
    @(posedge clk); #1;
    a_data = 8'h02;
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (44) @(posedge clk);
    #1;
    chk("midrst_data_cell", 32'(a_tx), 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_tx", 32'(a_tx), 32'd1);
    chk("midrst_busy", 32'(a_busy), 32'd0);
    chk("midrst_ready", 32'(a_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (a_tx !== 1'b1 || a_busy !== 1'b0) n++;
      @(posedge clk); #1;
    end
    chk("midrst_quiet_after", n, 0);
    mon_en = 1'b1;

    // Default parameters: start and first data cell of 0x41 last 10416 cycles each.
    push_one(3, 8'h41);
    @(posedge clk); #1;
    n = 0;
    while (d_tx === 1'b0 && n < 20000) begin
      n++;
      @(posedge clk); #1;
    end
    chk("default_start_cell", n, 10416);
    n = 0;
    while (d_tx === 1'b1 && n < 20000) begin
      n++;
      @(posedge clk); #1;
    end
    chk("default_bit0_cell", n, 10416);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
